// File: rtl/cycle_fetch_ctrl.sv
// cycle_fetch_ctrl: 8-phase machine-cycle sequencer (A1..X3) and instruction fetch.
// Drives the ROM address one nibble per phase and latches OPR/OPA in M1/M2.
// Recognises two-word instructions, fetches their second word and keeps the PC.
// Optional feature macro: INSN_CNT_EN adds a 16-bit completed-instruction counter.
module cycle_fetch_ctrl #(
    parameter logic [11:0] PC_RESET = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [3:0]  rom_data_in,
    input  logic        pc_load,
    input  logic [11:0] pc_load_addr,
    output logic [2:0]  cycle,
    output logic        sync,
    output logic [3:0]  rom_addr_nib,
    output logic        rom_rd,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic        word2_phase,
    output logic [7:0]  second_word,
    output logic [11:0] pc
`ifdef INSN_CNT_EN
    ,
    output logic [15:0] insn_count
`endif
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    phase_t      phase_reg, phase_next;
    logic [11:0] pc_reg, pc_next;
    logic [3:0]  opr_reg, opr_next;
    logic [3:0]  opa_reg, opa_next;
    logic [7:0]  second_word_reg, second_word_next;
    logic        word2_phase_reg, word2_phase_next;
    logic        two_word;
`ifdef INSN_CNT_EN
    logic [15:0] insn_count_reg, insn_count_next;
`endif

    // Two-word opcode detect from the latched first word (JCN, FIM, JUN, JMS, ISZ).
    always_comb begin
        two_word = 1'b0;
        case (opr_reg)
            4'h1, 4'h4, 4'h5, 4'h7: two_word = 1'b1;
            4'h2:                   two_word = ~opa_reg[0];
            default:                two_word = 1'b0;
        endcase
    end

    // State register; async reset discards any partially fetched instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg       <= PH_A1;
            pc_reg          <= PC_RESET;
            opr_reg         <= 4'h0;
            opa_reg         <= 4'h0;
            second_word_reg <= 8'h00;
            word2_phase_reg <= 1'b0;
`ifdef INSN_CNT_EN
            insn_count_reg  <= 16'h0000;
`endif
        end else begin
            phase_reg       <= phase_next;
            pc_reg          <= pc_next;
            opr_reg         <= opr_next;
            opa_reg         <= opa_next;
            second_word_reg <= second_word_next;
            word2_phase_reg <= word2_phase_next;
`ifdef INSN_CNT_EN
            insn_count_reg  <= insn_count_next;
`endif
        end
    end

    // Next-state: phase advance, nibble latching in M1/M2, PC and word-2 tracking at X3.
    always_comb begin
        phase_next       = phase_reg;
        pc_next          = pc_reg;
        opr_next         = opr_reg;
        opa_next         = opa_reg;
        second_word_next = second_word_reg;
        word2_phase_next = word2_phase_reg;
`ifdef INSN_CNT_EN
        insn_count_next  = insn_count_reg;
`endif
        if (clk_en) begin
            phase_next = phase_t'(phase_reg + 3'd1);
            case (phase_reg)
                PH_M1: begin
                    // opr stays frozen during a second-word cycle so the decoder
                    // sees one instruction spanning both machine cycles.
                    if (word2_phase_reg) second_word_next[7:4] = rom_data_in;
                    else                 opr_next              = rom_data_in;
                end
                PH_M2: begin
                    if (word2_phase_reg) second_word_next[3:0] = rom_data_in;
                    else                 opa_next              = rom_data_in;
                end
                PH_X3: begin
                    if (pc_load) begin
                        // A branch also cancels any pending second-word fetch.
                        pc_next          = pc_load_addr;
                        word2_phase_next = 1'b0;
                    end else begin
                        pc_next          = pc_reg + 12'd1;
                        word2_phase_next = two_word & ~word2_phase_reg;
                    end
`ifdef INSN_CNT_EN
                    // An instruction completes unless a second word is about to follow.
                    if (word2_phase_reg || !two_word || pc_load)
                        insn_count_next = insn_count_reg + 16'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Address nibble to ROM during A1..A3, low to high.
    always_comb begin
        rom_addr_nib = 4'h0;
        case (phase_reg)
            PH_A1:   rom_addr_nib = pc_reg[3:0];
            PH_A2:   rom_addr_nib = pc_reg[7:4];
            PH_A3:   rom_addr_nib = pc_reg[11:8];
            default: rom_addr_nib = 4'h0;
        endcase
    end

    assign cycle       = phase_reg;
    assign sync        = (phase_reg == PH_X3);
    assign rom_rd      = (phase_reg == PH_M1) || (phase_reg == PH_M2);
    assign opr         = opr_reg;
    assign opa         = opa_reg;
    assign word2_phase = word2_phase_reg;
    assign second_word = second_word_reg;
    assign pc          = pc_reg;
`ifdef INSN_CNT_EN
    assign insn_count  = insn_count_reg;
`endif

endmodule

// File: tb/tb_cycle_fetch_ctrl.sv
// tb_cycle_fetch_ctrl: scoreboard bench for cycle_fetch_ctrl.
// Each enabled/disabled clock pushes the expected post-edge outputs to a queue;
// after the edge the entry is popped and compared against the DUT.
module tb_cycle_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [3:0]  rom_data_in;
    logic        pc_load;
    logic [11:0] pc_load_addr;
    logic [2:0]  cycle;
    logic        sync;
    logic [3:0]  rom_addr_nib;
    logic        rom_rd;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        word2_phase;
    logic [7:0]  second_word;
    logic [11:0] pc;
`ifdef INSN_CNT_EN
    logic [15:0] insn_count;
`endif

    cycle_fetch_ctrl #(.PC_RESET(12'h000)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .rom_data_in  (rom_data_in),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .cycle        (cycle),
        .sync         (sync),
        .rom_addr_nib (rom_addr_nib),
        .rom_rd       (rom_rd),
        .opr          (opr),
        .opa          (opa),
        .word2_phase  (word2_phase),
        .second_word  (second_word),
        .pc           (pc)
`ifdef INSN_CNT_EN
        ,
        .insn_count   (insn_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  cyc;
        logic        syn;
        logic [3:0]  addr;
        logic        rd;
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic        w2;
        logic [7:0]  sw;
        logic [11:0] pc;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state
    logic [2:0]  e_cycle;
    logic [11:0] e_pc;
    logic [3:0]  e_opr, e_opa;
    logic [7:0]  e_sw;
    logic        e_w2;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic is_two_word(input logic [3:0] o, input logic [3:0] a);
        if (o == 4'h1 || o == 4'h4 || o == 4'h5 || o == 4'h7) return 1'b1;
        if (o == 4'h2) return (a[0] == 1'b0);
        return 1'b0;
    endfunction

    task automatic model_reset();
        e_cycle = 3'd0; e_pc = 12'h000; e_opr = 4'h0; e_opa = 4'h0;
        e_sw = 8'h00; e_w2 = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] rom, input logic ld,
                              input logic [11:0] addr, input logic en);
        if (!en) return;
        if (e_cycle == 3'd3) begin
            if (e_w2) e_sw[7:4] = rom; else e_opr = rom;
        end
        if (e_cycle == 3'd4) begin
            if (e_w2) e_sw[3:0] = rom; else e_opa = rom;
        end
        if (e_cycle == 3'd7) begin
            if (ld) begin
                e_pc = addr;
                e_w2 = 1'b0;
            end else begin
                e_pc = e_pc + 12'd1;
                e_w2 = is_two_word(e_opr, e_opa) && !e_w2;
            end
        end
        e_cycle = e_cycle + 3'd1;
    endtask

    function automatic exp_t snapshot();
        exp_t s;
        s.cyc  = e_cycle;
        s.syn  = (e_cycle == 3'd7);
        s.rd   = (e_cycle == 3'd3) || (e_cycle == 3'd4);
        s.addr = (e_cycle == 3'd0) ? e_pc[3:0] :
                 (e_cycle == 3'd1) ? e_pc[7:4] :
                 (e_cycle == 3'd2) ? e_pc[11:8] : 4'h0;
        s.opr  = e_opr;
        s.opa  = e_opa;
        s.w2   = e_w2;
        s.sw   = e_sw;
        s.pc   = e_pc;
        return s;
    endfunction

    task automatic compare_pop();
        exp_t s;
        if (sb_q.size() == 0) begin
            chk_val("sb_empty", 32'd0, 32'd1);
            return;
        end
        s = sb_q.pop_front();
        chk_val("cycle",       {29'd0, cycle},        {29'd0, s.cyc});
        chk_val("sync",        {31'd0, sync},         {31'd0, s.syn});
        chk_val("rom_addr",    {28'd0, rom_addr_nib}, {28'd0, s.addr});
        chk_val("rom_rd",      {31'd0, rom_rd},       {31'd0, s.rd});
        chk_val("opr",         {28'd0, opr},          {28'd0, s.opr});
        chk_val("opa",         {28'd0, opa},          {28'd0, s.opa});
        chk_val("word2_phase", {31'd0, word2_phase},  {31'd0, s.w2});
        chk_val("second_word", {24'd0, second_word},  {24'd0, s.sw});
        chk_val("pc",          {20'd0, pc},           {20'd0, s.pc});
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic tick(input logic [3:0] rom, input logic ld,
                        input logic [11:0] addr, input logic en);
        rom_data_in = rom; pc_load = ld; pc_load_addr = addr; clk_en = en;
        model_edge(rom, ld, addr, en);
        sb_q.push_back(snapshot());
        @(posedge clk);
        @(negedge clk);
        compare_pop();
        $display("tick en=%0b ld=%0b rom=%0h -> cycle=%0d pc=%03h opr=%0h opa=%0h w2=%0b sw=%02h",
                 en, ld, rom, cycle, pc, opr, opa, word2_phase, second_word);
    endtask

    // Tick until the next A1; ROM supplies hi/lo in M1/M2, load asserted only in phase ld_cyc.
    task automatic run_cycle(input logic [3:0] hi, input logic [3:0] lo, input logic ld,
                             input logic [11:0] addr, input logic [2:0] ld_cyc);
        int guard;
        logic [3:0] rom;
        guard = 0;
        do begin
            rom = (e_cycle == 3'd3) ? hi : (e_cycle == 3'd4) ? lo : 4'hE;
            tick(rom, ld && (e_cycle == ld_cyc), addr, 1'b1);
            guard++;
        end while (e_cycle != 3'd0 && guard < 16);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(snapshot());
        compare_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1; rom_data_in = 4'h0; pc_load = 1'b0; pc_load_addr = 12'h000;
        @(negedge clk);
        do_reset();

        // Plain 8 phases with constant ROM data; NOP keeps one-word behaviour.
        for (int i = 0; i < 8; i++) tick(4'h0, 1'b0, 12'h000, 1'b1);
        chk_val("pc_after_first", {20'd0, pc}, 32'h001);

        // Load 0x5A3, then watch address nibbles in A1..A3.
        run_cycle(4'h0, 4'h0, 1'b1, 12'h5A3, 3'd7);
        chk_val("addr_a1", {28'd0, rom_addr_nib}, 32'h3);
        tick(4'hE, 1'b0, 12'h000, 1'b1);
        chk_val("addr_a2", {28'd0, rom_addr_nib}, 32'hA);
        tick(4'hE, 1'b0, 12'h000, 1'b1);
        chk_val("addr_a3", {28'd0, rom_addr_nib}, 32'h5);
        run_cycle(4'h0, 4'h0, 1'b0, 12'h000, 3'd7);
        chk_val("pc_5a4", {20'd0, pc}, 32'h5A4);

        // JUN 0x41 followed by second word 0x2C.
        run_cycle(4'h4, 4'h1, 1'b0, 12'h000, 3'd7);
        chk_val("jun_w2", {31'd0, word2_phase}, 32'd1);
        run_cycle(4'h2, 4'hC, 1'b0, 12'h000, 3'd7);
        chk_val("jun_opr_held", {28'd0, opr}, 32'h4);
        chk_val("jun_opa_held", {28'd0, opa}, 32'h1);
        chk_val("jun_word2", {24'd0, second_word}, 32'h2C);
        chk_val("jun_w2_clear", {31'd0, word2_phase}, 32'd0);
        chk_val("jun_pc_plus2", {20'd0, pc}, 32'h5A6);

        // FIM is two words; SRC is one word.
        run_cycle(4'h2, 4'h0, 1'b0, 12'h000, 3'd7);
        chk_val("fim_w2", {31'd0, word2_phase}, 32'd1);
        run_cycle(4'h5, 4'h5, 1'b0, 12'h000, 3'd7);
        chk_val("fim_word2", {24'd0, second_word}, 32'h55);
        run_cycle(4'h2, 4'h1, 1'b0, 12'h000, 3'd7);
        chk_val("src_w2", {31'd0, word2_phase}, 32'd0);

        // PC wrap, branch load, load outside X3 ignored, load cancels pending word 2.
        run_cycle(4'h0, 4'h0, 1'b1, 12'hFFF, 3'd7);
        run_cycle(4'h0, 4'h0, 1'b0, 12'h000, 3'd7);
        chk_val("pc_wrap", {20'd0, pc}, 32'h000);
        run_cycle(4'h0, 4'h0, 1'b1, 12'h123, 3'd7);
        chk_val("pc_load", {20'd0, pc}, 32'h123);
        run_cycle(4'h0, 4'h0, 1'b1, 12'h777, 3'd5);
        chk_val("pc_load_x1_ignored", {20'd0, pc}, 32'h124);
        run_cycle(4'h4, 4'h0, 1'b1, 12'h200, 3'd7);
        chk_val("load_cancel_w2", {31'd0, word2_phase}, 32'd0);
        chk_val("load_cancel_pc", {20'd0, pc}, 32'h200);

        // Freeze at M2 for three clocks with garbage on the ROM bus.
        for (int i = 0; i < 4; i++) tick((e_cycle == 3'd3) ? 4'hD : 4'hE, 1'b0, 12'h000, 1'b1);
        chk_val("at_m2", {29'd0, cycle}, 32'd4);
        for (int i = 0; i < 3; i++) tick(4'h9, 1'b1, 12'hABC, 1'b0);
        chk_val("frozen_cycle", {29'd0, cycle}, 32'd4);
        chk_val("frozen_opr", {28'd0, opr}, 32'hD);
        tick(4'h6, 1'b0, 12'h000, 1'b1);
        chk_val("resume_opa", {28'd0, opa}, 32'h6);

        // Async reset at X1 takes effect without a clock edge.
        rst = 1'b1;
        model_reset();
        #1;
        chk_val("rst_cycle", {29'd0, cycle}, 32'd0);
        chk_val("rst_pc", {20'd0, pc}, 32'h000);
        chk_val("rst_opr", {28'd0, opr}, 32'h0);
        chk_val("rst_opa", {28'd0, opa}, 32'h0);
        chk_val("rst_rd", {31'd0, rom_rd}, 32'd0);
        chk_val("rst_sync", {31'd0, sync}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_cycle(4'h7, 4'h3, 1'b0, 12'h000, 3'd7);
        chk_val("post_rst_isz_w2", {31'd0, word2_phase}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cycle_fetch_ctrl.md
Name: cycle_fetch_ctrl

Overview:
Instruction-cycle timing generator and fetch unit directly upstream of the decoder/CC stage. It runs the 8-phase machine cycle A1..X3, drives the 12-bit ROM address out one nibble per phase, and latches the ROM data nibbles into OPR/OPA. It also recognises two-word instructions, fetches their second word, and maintains the program counter. Outputs cycle/opr/opa feed the decoder unchanged.

Parameters:
PC_RESET, 12'h000, program counter value after reset.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
clk_en  in  1  phase advance enable; low = freeze all state
rom_data_in  in  4  ROM data nibble, sampled in M1/M2
pc_load  in  1  branch request from decoder, sampled at end of X3
pc_load_addr  in  12  branch target
cycle  out  3  0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3
sync  out  1  high while cycle==7 (X3), marks next A1
rom_addr_nib  out  4  address nibble to ROM (combinational from cycle/pc)
rom_rd  out  1  high during M1 and M2
opr  out  4  instruction high nibble (first word)
opa  out  4  instruction low nibble (first word)
word2_phase  out  1  current machine cycle is fetching a second word
second_word  out  8  latched second word {hi,lo}
pc  out  12  program counter

Behaviour:
- Reset (async, rst=1): cycle=0, pc=PC_RESET, opr=opa=0, second_word=0, word2_phase=0, pending=0; sync=0, rom_rd=0. Release takes effect on next clk edge with clk_en.
- clk_en=0: every register holds; combinational outputs follow held state.
- cycle: +1 per enabled edge, 7 wraps to 0.
- rom_addr_nib: A1 pc[3:0], A2 pc[7:4], A3 pc[11:8], other phases 4'h0.
- rom_rd=1 iff cycle∈{3,4}. sync=1 iff cycle==7.
- M1 edge (cycle==3, clk_en): word2_phase=0 -> opr<=rom_data_in; else second_word[7:4]<=rom_data_in.
- M2 edge (cycle==4, clk_en): word2_phase=0 -> opa<=rom_data_in; else second_word[3:0]<=rom_data_in.
- opr/opa hold through the second-word cycle so the decoder sees one instruction for both cycles.
- Two-word detect, evaluated at X3 of first-word cycle from opr/opa: opr∈{1 JCN, 4 JUN, 5 JMS, 7 ISZ}, or opr==2 with opa[0]==0 (FIM). SRC (opr 2, opa[0]=1) is one word.
- X3 edge (cycle==7, clk_en):
  - pc_load=1 -> pc<=pc_load_addr, word2_phase<=0 (load cancels pending second word).
  - else pc<=pc+1 (12-bit wrap FFF->000); word2_phase<=two-word-detect && !word2_phase.
- Second word never re-triggers detection: after a word2 cycle, word2_phase returns to 0.
- pc_load outside X3 ignored.
- rst mid-cycle: immediate return to reset state; partial fetch discarded.

Optional Feature:
INSN_CNT_EN: when defined, adds output insn_count[15:0], reset 0, incremented (16-bit wrap) at each X3 edge that completes an instruction, i.e. when word2_phase=1, or word2_phase=0 and no two-word detect (load-cancelled first words also count). When undefined, the port and counter are absent. Timing of all other outputs is identical either way.

Test Plan:
- Reset then 8 enabled clocks with rom_data_in const -> cycle 0..7,0; sync only at 7; rom_rd only at 3,4; pc 000->001.
- pc=0x5A3, step A1..A3 -> rom_addr_nib 3,A,5.
- Feed 0x4 at M1, 0x1 at M2 (JUN), next cycle 0x2,0xC -> opr=4 opa=1 held; word2_phase=1 in second cycle; second_word=0x2C; pc +2 total.
- Feed FIM 0x20 -> word2_phase=1; feed SRC 0x21 -> word2_phase stays 0.
- pc=0xFFF, one-word NOP -> pc=0x000 after X3; pc_load=1 addr 0x123 at X3 -> pc=0x123; pc_load=1 at cycle 5 -> ignored.
- clk_en=0 for 3 clocks at cycle 4 -> all outputs unchanged; rst asserted at cycle 5 -> cycle=0, pc=PC_RESET, opr=opa=0 immediately.
